// File: rtl/ddr_write_arbiter.sv
// Arbitrates the DDR2 write path (address FIFO + write-data FIFO) between FrameFiller and
// LineEngine. Only whole transactions are granted, so beats from the two masters never interleave.
module ddr_write_arbiter #(
  parameter int BEATS   = 2,
  parameter int MAX_TXN = 8
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         ff_req,
  output logic         ff_gnt,
  input  logic [30:0]  ff_af_addr_din,
  input  logic         ff_af_wr_en,
  input  logic [127:0] ff_wdf_din,
  input  logic [15:0]  ff_wdf_mask_din,
  input  logic         ff_wdf_wr_en,
  output logic         ff_af_full,
  output logic         ff_wdf_full,

  input  logic         le_req,
  output logic         le_gnt,
  input  logic [30:0]  le_af_addr_din,
  input  logic         le_af_wr_en,
  input  logic [127:0] le_wdf_din,
  input  logic [15:0]  le_wdf_mask_din,
  input  logic         le_wdf_wr_en,
  output logic         le_af_full,
  output logic         le_wdf_full,

  output logic [2:0]   af_cmd_din,
  output logic [30:0]  af_addr_din,
  output logic         af_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en,
  input  logic         af_full,
  input  logic         wdf_full
);

  localparam int BW = $clog2(BEATS + 1);
  localparam int TW = $clog2(MAX_TXN + 1);
  localparam logic [BW-1:0] BEATS_L = BW'(BEATS);
  localparam logic [TW-1:0] MAX_L   = TW'(MAX_TXN);

  typedef enum logic [1:0] {IDLE, GNT_FF, GNT_LE} state_t;

  state_t        state_q, state_d;
  logic          last_le_q, last_le_d;
  logic          cmd_done_q, cmd_done_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] txn_q, txn_d;

  logic          own_req, other_req, own_af_wr, own_wdf_wr;
  logic          beat_lock, gated_af_full, gated_wdf_full;
  logic          cmd_acc, beat_acc, cmd_nx, done;
  logic [BW-1:0] beat_nx;
  logic [TW-1:0] txn_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_le_q  <= 1'b1;
      cmd_done_q <= 1'b0;
      beat_q     <= '0;
      txn_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_le_q  <= last_le_d;
      cmd_done_q <= cmd_done_d;
      beat_q     <= beat_d;
      txn_q      <= txn_d;
    end
  end

  always_comb begin
    own_req      = 1'b0;
    other_req    = 1'b0;
    own_af_wr    = 1'b0;
    own_wdf_wr   = 1'b0;
    af_addr_din  = '0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    case (state_q)
      GNT_FF: begin
        own_req      = ff_req;
        other_req    = le_req;
        own_af_wr    = ff_af_wr_en;
        own_wdf_wr   = ff_wdf_wr_en;
        af_addr_din  = ff_af_addr_din;
        wdf_din      = ff_wdf_din;
        wdf_mask_din = ff_wdf_mask_din;
      end
      GNT_LE: begin
        own_req      = le_req;
        other_req    = ff_req;
        own_af_wr    = le_af_wr_en;
        own_wdf_wr   = le_wdf_wr_en;
        af_addr_din  = le_af_addr_din;
        wdf_din      = le_wdf_din;
        wdf_mask_din = le_wdf_mask_din;
      end
      default: ;
    endcase

    // Once the command or all beats of this transaction are in, that FIFO looks full to the owner.
    beat_lock      = (beat_q == BEATS_L);
    gated_af_full  = af_full | cmd_done_q;
    gated_wdf_full = wdf_full | beat_lock;
    af_wr_en       = own_af_wr & ~cmd_done_q;
    wdf_wr_en      = own_wdf_wr & ~beat_lock;
    af_cmd_din     = 3'b000;

    ff_gnt      = (state_q == GNT_FF);
    le_gnt      = (state_q == GNT_LE);
    ff_af_full  = ff_gnt ? gated_af_full  : 1'b1;
    ff_wdf_full = ff_gnt ? gated_wdf_full : 1'b1;
    le_af_full  = le_gnt ? gated_af_full  : 1'b1;
    le_wdf_full = le_gnt ? gated_wdf_full : 1'b1;

    cmd_acc  = af_wr_en & ~af_full;
    beat_acc = wdf_wr_en & ~wdf_full;
    cmd_nx   = cmd_done_q | cmd_acc;
    beat_nx  = beat_q + BW'(beat_acc);
    done     = (state_q != IDLE) && cmd_nx && (beat_nx == BEATS_L);
    txn_nx   = (txn_q == MAX_L) ? txn_q : txn_q + 1'b1;

    state_d    = state_q;
    last_le_d  = last_le_q;
    cmd_done_d = cmd_nx;
    beat_d     = beat_nx;
    txn_d      = txn_q;

    if (state_q == IDLE) begin
      cmd_done_d = 1'b0;
      beat_d     = '0;
      txn_d      = '0;
      if (ff_req && le_req) begin
        state_d   = last_le_q ? GNT_FF : GNT_LE;
        last_le_d = ~last_le_q;
      end else if (ff_req) begin
        state_d   = GNT_FF;
        last_le_d = 1'b0;
      end else if (le_req) begin
        state_d   = GNT_LE;
        last_le_d = 1'b1;
      end
    end else if (done) begin
      cmd_done_d = 1'b0;
      beat_d     = '0;
      txn_d      = txn_nx;
      if (!own_req || (txn_nx >= MAX_L && other_req)) begin
        state_d = IDLE;
        txn_d   = '0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Directed bench for ddr_write_arbiter: a per-cycle vector table plus hand sequences for
// round-robin fairness, FIFO back-pressure and mid-transaction reset.
module tb_ddr_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ff_req, ff_gnt, ff_af_wr_en, ff_wdf_wr_en, ff_af_full, ff_wdf_full;
  logic         le_req, le_gnt, le_af_wr_en, le_wdf_wr_en, le_af_full, le_wdf_full;
  logic [30:0]  ff_af_addr_din, le_af_addr_din, af_addr_din;
  logic [127:0] ff_wdf_din, le_wdf_din, wdf_din;
  logic [15:0]  ff_wdf_mask_din, le_wdf_mask_din, wdf_mask_din;
  logic [2:0]   af_cmd_din;
  logic         af_wr_en, wdf_wr_en, af_full, wdf_full;

  localparam logic [30:0]  FF_ADDR = 31'h0F0F_0001;
  localparam logic [30:0]  LE_ADDR = 31'h1234_0002;
  localparam logic [127:0] FF_DATA = {4{32'hF0F0_0001}};
  localparam logic [127:0] LE_DATA = {4{32'h1E1E_0002}};
  localparam logic [15:0]  FF_MASK = 16'h00FF;
  localparam logic [15:0]  LE_MASK = 16'hF000;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ddr_write_arbiter #(.BEATS(2), .MAX_TXN(8)) dut (
    .clk(clk), .rst(rst),
    .ff_req(ff_req), .ff_gnt(ff_gnt), .ff_af_addr_din(ff_af_addr_din), .ff_af_wr_en(ff_af_wr_en),
    .ff_wdf_din(ff_wdf_din), .ff_wdf_mask_din(ff_wdf_mask_din), .ff_wdf_wr_en(ff_wdf_wr_en),
    .ff_af_full(ff_af_full), .ff_wdf_full(ff_wdf_full),
    .le_req(le_req), .le_gnt(le_gnt), .le_af_addr_din(le_af_addr_din), .le_af_wr_en(le_af_wr_en),
    .le_wdf_din(le_wdf_din), .le_wdf_mask_din(le_wdf_mask_din), .le_wdf_wr_en(le_wdf_wr_en),
    .le_af_full(le_af_full), .le_wdf_full(le_wdf_full),
    .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
    .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
    .af_full(af_full), .wdf_full(wdf_full)
  );

  typedef struct {
    logic ffr, ler, ffa, ffw, lea, lew, afl, wfl;
    logic e_ffg, e_leg, e_af, e_wdf, e_ffaf, e_ffwf, e_leaf, e_lewf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ff_req = 0; ff_af_wr_en = 0; ff_wdf_wr_en = 0;
    le_req = 0; le_af_wr_en = 0; le_wdf_wr_en = 0;
    af_full = 0; wdf_full = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ff_gnt"}, ff_gnt, 0);
    chk({tag, " le_gnt"}, le_gnt, 0);
    chk({tag, " af_wr_en"}, af_wr_en, 0);
    chk({tag, " wdf_wr_en"}, wdf_wr_en, 0);
    chk({tag, " fulls"}, {ff_af_full, ff_wdf_full, le_af_full, le_wdf_full}, 4'hF);
    chk({tag, " wdf_din"}, wdf_din, 0);
  endtask

  initial begin
    logic [127:0] exp_data;
    logic [30:0]  exp_addr;
    logic [15:0]  exp_mask;
    int runs, cur_run, cur_beats, bad_data;
    logic exp_owner_le, run_owner_le, ff_go, le_go, ff_ph, le_ph;

    ff_af_addr_din = FF_ADDR; ff_wdf_din = FF_DATA; ff_wdf_mask_din = FF_MASK;
    le_af_addr_din = LE_ADDR; le_wdf_din = LE_DATA; le_wdf_mask_din = LE_MASK;

    //            ffr ler ffa ffw lea lew afl wfl | ffg leg af wdf ffaf ffwf leaf lewf
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1};
    vecs[1]  = '{1, 0, 1, 1, 0, 1, 0, 0,  1, 0, 1, 1, 0, 0, 1, 1};
    vecs[2]  = '{0, 0, 0, 1, 0, 1, 0, 0,  1, 0, 0, 1, 1, 0, 1, 1};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1};
    vecs[4]  = '{1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1};
    vecs[5]  = '{1, 0, 0, 1, 1, 1, 0, 0,  0, 1, 1, 1, 1, 1, 0, 0};
    vecs[6]  = '{1, 0, 0, 1, 0, 1, 0, 0,  0, 1, 0, 1, 1, 1, 1, 0};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1};
    vecs[8]  = '{1, 0, 1, 1, 0, 0, 0, 1,  1, 0, 1, 1, 0, 1, 1, 1};
    vecs[9]  = '{1, 0, 0, 1, 0, 0, 1, 0,  1, 0, 0, 1, 1, 0, 1, 1};
    vecs[10] = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 1, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1};

    rst = 1;
    clear_inputs();
    tick();
    #1;
    chk_idle_outputs("reset");
    chk("af_cmd_din", af_cmd_din, 3'b000);
    tick();
    rst = 0;

    // Per-cycle table: single FF txn, round-robin tie to LE, LE txn, back-pressured FF txn.
    for (int i = 0; i < 12; i++) begin
      ff_req = vecs[i].ffr; le_req = vecs[i].ler;
      ff_af_wr_en = vecs[i].ffa; ff_wdf_wr_en = vecs[i].ffw;
      le_af_wr_en = vecs[i].lea; le_wdf_wr_en = vecs[i].lew;
      af_full = vecs[i].afl; wdf_full = vecs[i].wfl;
      #1;
      exp_addr = vecs[i].e_ffg ? FF_ADDR : vecs[i].e_leg ? LE_ADDR : 31'h0;
      exp_data = vecs[i].e_ffg ? FF_DATA : vecs[i].e_leg ? LE_DATA : 128'h0;
      exp_mask = vecs[i].e_ffg ? FF_MASK : vecs[i].e_leg ? LE_MASK : 16'h0;
      chk($sformatf("v%0d ff_gnt", i), ff_gnt, vecs[i].e_ffg);
      chk($sformatf("v%0d le_gnt", i), le_gnt, vecs[i].e_leg);
      chk($sformatf("v%0d af_wr_en", i), af_wr_en, vecs[i].e_af);
      chk($sformatf("v%0d wdf_wr_en", i), wdf_wr_en, vecs[i].e_wdf);
      chk($sformatf("v%0d ff_af_full", i), ff_af_full, vecs[i].e_ffaf);
      chk($sformatf("v%0d ff_wdf_full", i), ff_wdf_full, vecs[i].e_ffwf);
      chk($sformatf("v%0d le_af_full", i), le_af_full, vecs[i].e_leaf);
      chk($sformatf("v%0d le_wdf_full", i), le_wdf_full, vecs[i].e_lewf);
      chk($sformatf("v%0d af_addr_din", i), af_addr_din, exp_addr);
      chk($sformatf("v%0d wdf_din", i), wdf_din, exp_data);
      chk($sformatf("v%0d wdf_mask_din", i), wdf_mask_din, exp_mask);
      tick();
    end

    // Tie right after reset goes to FF; LE follows after one IDLE cycle.
    do_reset();
    ff_req = 1; le_req = 1;
    tick();
    chk("tie ff_gnt", ff_gnt, 1);
    chk("tie le_gnt", le_gnt, 0);
    ff_af_wr_en = 1; ff_wdf_wr_en = 1; ff_req = 0;
    tick();
    ff_af_wr_en = 0;
    tick();
    ff_wdf_wr_en = 0;
    chk("tie idle gap ff_gnt", ff_gnt, 0);
    chk("tie idle gap le_gnt", le_gnt, 0);
    tick();
    chk("tie then le_gnt", le_gnt, 1);
    le_req = 0;

    // Both masters saturating: runs of exactly MAX_TXN alternate, no foreign beats.
    do_reset();
    ff_req = 1; le_req = 1;
    runs = 0; cur_run = 0; cur_beats = 0; bad_data = 0;
    exp_owner_le = 0; run_owner_le = 0; ff_ph = 0; le_ph = 0;
    for (int cyc = 0; cyc < 400 && runs < 4; cyc++) begin
      ff_af_wr_en  = ff_gnt && !ff_ph;
      ff_wdf_wr_en = ff_gnt;
      le_af_wr_en  = le_gnt && !le_ph;
      le_wdf_wr_en = le_gnt;
      #1;
      if (wdf_wr_en) begin
        cur_beats++;
        if (wdf_din !== (ff_gnt ? FF_DATA : LE_DATA)) bad_data++;
      end
      if (af_wr_en) begin
        cur_run++;
        run_owner_le = le_gnt;
      end
      if (!ff_gnt && !le_gnt && cur_run > 0) begin
        chk($sformatf("run%0d txn count", runs), cur_run, 8);
        chk($sformatf("run%0d beat count", runs), cur_beats, 16);
        chk($sformatf("run%0d owner_le", runs), run_owner_le, exp_owner_le);
        exp_owner_le = ~exp_owner_le;
        runs++;
        cur_run = 0;
        cur_beats = 0;
      end
      ff_go = ff_gnt; le_go = le_gnt;
      tick();
      ff_ph = ff_go ? ~ff_ph : 1'b0;
      le_ph = le_go ? ~le_ph : 1'b0;
    end
    chk("fairness runs seen", runs, 4);
    chk("fairness foreign data", bad_data, 0);
    clear_inputs();
    tick();
    tick();

    // wdf_full held for 5 cycles after beat 0; owner req drops and must be ignored.
    do_reset();
    ff_req = 1;
    tick();
    ff_af_wr_en = 1; ff_wdf_wr_en = 1; ff_req = 0;
    tick();
    ff_af_wr_en = 0; wdf_full = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d ff_gnt", k), ff_gnt, 1);
      chk($sformatf("bp%0d ff_wdf_full", k), ff_wdf_full, 1);
      chk($sformatf("bp%0d le_wdf_full", k), le_wdf_full, 1);
      tick();
    end
    wdf_full = 0;
    #1;
    chk("bp release ff_gnt", ff_gnt, 1);
    chk("bp release ff_wdf_full", ff_wdf_full, 0);
    chk("bp release le_wdf_full", le_wdf_full, 1);
    tick();
    ff_wdf_wr_en = 0;
    chk("bp complete ff_gnt", ff_gnt, 0);

    // Reset between command and beat 1 abandons the transaction.
    do_reset();
    ff_req = 1;
    tick();
    ff_af_wr_en = 1; ff_wdf_wr_en = 1;
    tick();
    ff_af_wr_en = 0; ff_wdf_wr_en = 0; rst = 1;
    tick();
    ff_af_wr_en = 1; ff_wdf_wr_en = 1;
    #1;
    chk_idle_outputs("midrst");
    rst = 0; ff_af_wr_en = 0; ff_wdf_wr_en = 0;
    tick();
    chk("midrst regrant ff_gnt", ff_gnt, 1);
    chk("midrst fresh ff_af_full", ff_af_full, 0);
    chk("midrst fresh ff_wdf_full", ff_wdf_full, 0);
    ff_af_wr_en = 1; ff_wdf_wr_en = 1; ff_req = 0;
    tick();
    ff_af_wr_en = 0;
    chk("midrst beat0 still granted", ff_gnt, 1);
    tick();
    ff_wdf_wr_en = 0;
    chk("midrst complete ff_gnt", ff_gnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ddr_write_arbiter.md
Name: ddr_write_arbiter

Overview:
- Shares the single DDR2 write path (MIG address FIFO plus write-data FIFO) between two graphics write masters: FrameFiller (FF) and LineEngine (LE).
- Grants whole transactions only. One transaction is one address-FIFO command plus BEATS write-data beats, so beats from different masters never interleave.
- Sits between the graphics engines and the memory-interface FIFOs.

Parameters:
- BEATS, 2, write-data beats (128-bit each) per address command.
- MAX_TXN, 8, transactions one master may issue back-to-back while the other is requesting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ff_req  in  1  FF has a pending transaction
- ff_gnt  out  1  FF owns the write path
- ff_af_addr_din  in  31  FF command address
- ff_af_wr_en  in  1  FF command write
- ff_wdf_din  in  128  FF write data
- ff_wdf_mask_din  in  16  FF byte mask, 1 = masked
- ff_wdf_wr_en  in  1  FF data write
- ff_af_full  out  1  gated address-FIFO full seen by FF
- ff_wdf_full  out  1  gated data-FIFO full seen by FF
- le_req, le_gnt, le_af_addr_din, le_af_wr_en, le_wdf_din, le_wdf_mask_din, le_wdf_wr_en, le_af_full, le_wdf_full: same as the ff_ ports, for LE
- af_cmd_din  out  3  fixed 3'b000 (write)
- af_addr_din  out  31  muxed address
- af_wr_en  out  1  muxed command write
- wdf_din  out  128  muxed data
- wdf_mask_din  out  16  muxed mask
- wdf_wr_en  out  1  muxed data write
- af_full  in  1  address FIFO full
- wdf_full  in  1  data FIFO full

Behaviour:
- States: IDLE, GNT_FF, GNT_LE. All state is registered.
  - ff_gnt = (state==GNT_FF); le_gnt = (state==GNT_LE).
- Datapath mux is combinational from the registered state:
  - af_wr_en = granted master's af_wr_en; wdf_wr_en = granted master's wdf_wr_en. Both are 0 in IDLE.
  - af_addr_din, wdf_din, wdf_mask_din come from the granted master; they are 0 in IDLE.
- Full gating:
  - The granted master sees the real af_full and wdf_full.
  - The non-granted master, and both masters in IDLE, see 1 on both full outputs.
  - Write enables from a non-granted master are dropped and never reach the FIFOs.
- Accept events:
  - Command accepted = af_wr_en & !af_full.
  - Beat accepted = wdf_wr_en & !wdf_full.
  - A command and a beat may be accepted in the same cycle.
- Per-transaction tracking: cmd_done flag and beat_cnt (0..BEATS).
  - Transaction completes on the cycle where cmd_done and beat_cnt == BEATS both become true, including when the last accepts happen simultaneously.
  - On completion, cmd_done and beat_cnt clear and txn_cnt increments.
  - Extra commands, or beats beyond BEATS, before completion are not accepted: the granted master sees full = 1 for that FIFO.
- IDLE arbitration:
  - Only one requester: grant it next cycle.
  - Both requesting: grant the master that is not last_gnt (round-robin).
  - last_gnt updates on every grant; reset value is LE, so FF wins the first tie.
  - Grant latency is 1 cycle from req to gnt.
- Release: on a completion cycle, next state is IDLE if either
  - the owner's req is low, or
  - txn_cnt has reached MAX_TXN and the other master's req is high.
  Otherwise the grant is held and txn_cnt counts on.
- Release always passes through one IDLE cycle; txn_cnt clears on entering IDLE.
- req dropping mid-transaction is ignored: the grant is held until completion.
- Reset (any cycle, including mid-transaction):
  - State goes to IDLE; counters and flags go to 0; last_gnt goes to LE.
  - All FIFO write outputs and data go to 0; gnts go to 0; all four gated full outputs go to 1.
  - Partially written transactions are abandoned.

Test Plan:
- FF only requests, BEATS=2, FIFOs empty, command with beat 0, then beat 1 -> ff_gnt one cycle after ff_req; af_wr_en=1 once, wdf_wr_en=1 twice, addresses and data pass unchanged; IDLE on the cycle after completion once ff_req drops.
- ff_req and le_req rise the same cycle after reset -> FF granted first; after FF completes one transaction with req dropped, LE granted after one IDLE cycle.
- Both requesters held high, MAX_TXN=8 -> FF completes exactly 8 transactions, then IDLE, then LE gets 8; this alternation repeats and no beats are interleaved.
- wdf_full=1 for 5 cycles mid-transaction after beat 0 -> beat 1 held; grant retained; completion only after wdf_full drops; le_wdf_full stays 1 throughout.
- LE pulses le_wdf_wr_en while FF is granted -> wdf_wr_en stays FF-only; LE data never appears on wdf_din.
- rst asserted after command accepted but before beat 1 -> next cycle state IDLE, gnts 0, all gated fulls 1, counters 0; FF re-granted fresh after release if ff_req is high.
